// File: rtl/fb_mem_sched.sv
// Framebuffer RAM scheduler: arbitrates scanout reads against host writes,
// issues registered RAM commands and owns the vblank-synchronised bank swap.
module fb_mem_sched #(
   parameter int AW      = 9,
   parameter int DW      = 4,
   parameter int MEM_LAT = 1,
   parameter int STARVE  = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          rd_req,
   input  logic [AW-1:0] rd_addr,
   output logic          rd_gnt,
   output logic          rd_valid,
   output logic [DW-1:0] rd_data,
   input  logic          wr_req,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   output logic          wr_gnt,
   input  logic          swap_req,
   input  logic          vblank,
   output logic          swap_pending,
   output logic          swap_done,
   output logic          disp_bank,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW:0]   mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   localparam logic [7:0] STARVE_C = 8'(STARVE);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PEND = 2'd1,
      S_SWAP = 2'd2
   } swap_st_t;

   logic [7:0]         r_wait_cnt;
   logic               r_mem_en;
   logic               r_mem_we;
   logic [AW:0]        r_mem_addr;
   logic [DW-1:0]      r_mem_wdata;
   logic [MEM_LAT-1:0] r_rdv;
   logic               r_disp_bank;
   logic               r_vblank_q;
   swap_st_t           r_state;
   swap_st_t           w_state_nxt;
   logic               w_wr_pri;
   logic               w_rd_gnt;
   logic               w_wr_gnt;
   logic               w_vb_rise;

   // Arbitration: starved host beats scanout, otherwise scanout first
   always_comb begin
      w_wr_pri = wr_req && (r_wait_cnt == STARVE_C);
      w_rd_gnt = rd_req && !w_wr_pri;
      w_wr_gnt = wr_req && !w_rd_gnt;
   end

   assign rd_gnt = w_rd_gnt;
   assign wr_gnt = w_wr_gnt;

   // Count consecutive denied host cycles, saturating at the starve limit
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wait_cnt <= '0;
      end else if (!wr_req || w_wr_gnt) begin
         r_wait_cnt <= '0;
      end else if (r_wait_cnt != STARVE_C) begin
         r_wait_cnt <= r_wait_cnt + 8'd1;
      end
   end

   // Register the granted command; bank is frozen at grant time
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mem_en    <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
      end else begin
         r_mem_en <= w_rd_gnt || w_wr_gnt;
         r_mem_we <= w_wr_gnt;
         if (w_wr_gnt) begin
            r_mem_addr  <= {~r_disp_bank, wr_addr};
            r_mem_wdata <= wr_data;
         end else if (w_rd_gnt) begin
            r_mem_addr <= {r_disp_bank, rd_addr};
         end
      end
   end

   assign mem_en    = r_mem_en;
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;

   // Track issued reads through the RAM latency to flag returning data
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rdv <= '0;
      end else begin
         r_rdv[0] <= r_mem_en && !r_mem_we;
         for (int i = 1; i < MEM_LAT; i++) begin
            r_rdv[i] <= r_rdv[i-1];
         end
      end
   end

   assign rd_valid = r_rdv[MEM_LAT-1];
   assign rd_data  = rd_valid ? mem_rdata : '0;

   assign w_vb_rise = vblank && !r_vblank_q;

   // Swap FSM state register plus vblank edge history
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_vblank_q <= 1'b1;
      end else begin
         r_state    <= w_state_nxt;
         r_vblank_q <= vblank;
      end
   end

   // Swap FSM next state: request waits for the next vblank rising edge
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE: if (swap_req) w_state_nxt = S_PEND;
         S_PEND: if (w_vb_rise) w_state_nxt = S_SWAP;
         S_SWAP: w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Swap FSM outputs
   always_comb begin
      swap_pending = (r_state == S_PEND) || (r_state == S_SWAP);
      swap_done    = (r_state == S_SWAP);
   end

   // Displayed bank flips on entry to the swap cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_disp_bank <= 1'b0;
      end else if ((r_state == S_PEND) && w_vb_rise) begin
         r_disp_bank <= ~r_disp_bank;
      end
   end

   assign disp_bank = r_disp_bank;

endmodule

// File: tb/tb_fb_mem_sched.sv
// Bench for fb_mem_sched: directed vector table, swap/reset sequences and
// random traffic checked against a cycle-level behavioural model.
module tb_fb_mem_sched;

   localparam int AW     = 9;
   localparam int DW     = 4;
   localparam int LAT    = 1;
   localparam int STARVE = 8;

   logic          clk;
   logic          rst;
   logic          rd_req;
   logic [AW-1:0] rd_addr;
   logic          rd_gnt;
   logic          rd_valid;
   logic [DW-1:0] rd_data;
   logic          wr_req;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          wr_gnt;
   logic          swap_req;
   logic          vblank;
   logic          swap_pending;
   logic          swap_done;
   logic          disp_bank;
   logic          mem_en;
   logic          mem_we;
   logic [AW:0]   mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   fb_mem_sched #(
      .AW(AW), .DW(DW), .MEM_LAT(LAT), .STARVE(STARVE)
   ) dut (
      .clk(clk), .rst(rst),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
      .rd_valid(rd_valid), .rd_data(rd_data),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_gnt(wr_gnt),
      .swap_req(swap_req), .vblank(vblank),
      .swap_pending(swap_pending), .swap_done(swap_done),
      .disp_bank(disp_bank),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM with one cycle read latency
   logic [DW-1:0] ram [0:1023];
   logic [DW-1:0] ram_q;
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) ram[mem_addr] <= mem_wdata;
         else        ram_q <= ram[mem_addr];
      end
   end
   assign mem_rdata = ram_q;

   // Reference model state
   typedef struct {
      int           due;
      logic [DW-1:0] d;
   } ret_t;

   int            total;
   int            bad;
   int            cyc_n;
   logic [DW-1:0] shadow [0:1023];
   ret_t          rq [$];
   int            m_wait;
   bit            m_en;
   bit            m_we;
   logic [AW:0]   m_addr;
   logic [DW-1:0] m_wd;
   bit            m_bank;
   bit            m_pend;
   bit            m_swp;
   bit            m_vq;
   bit            g_rg;
   bit            g_wg;
   bit            s_rg;
   bit            s_wg;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc_n, act, exp);
      end
   endtask

   task automatic model_reset();
      m_wait = 0;
      m_en   = 0;
      m_we   = 0;
      m_addr = '0;
      m_wd   = '0;
      m_bank = 0;
      m_pend = 0;
      m_swp  = 0;
      m_vq   = 1;
      g_rg   = 0;
      g_wg   = 0;
      rq.delete();
   endtask

   // One clock cycle: compare at negedge, advance model, step past posedge
   task automatic cyc();
      bit pri, erg, ewg, rise, nsw;
      @(negedge clk);
      pri = wr_req && (m_wait >= STARVE);
      erg = rd_req && !pri;
      ewg = wr_req && !erg;
      s_rg = rd_gnt;
      s_wg = wr_gnt;
      chk("rd_gnt", 32'(rd_gnt), 32'(erg));
      chk("wr_gnt", 32'(wr_gnt), 32'(ewg));
      chk("mem_en", 32'(mem_en), 32'(m_en));
      chk("mem_we", 32'(mem_we), 32'(m_we));
      if (m_en) chk("mem_addr", 32'(mem_addr), 32'(m_addr));
      if (m_en && m_we) chk("mem_wdata", 32'(mem_wdata), 32'(m_wd));
      if (rq.size() > 0 && rq[0].due == cyc_n) begin
         chk("rd_valid", 32'(rd_valid), 32'd1);
         chk("rd_data", 32'(rd_data), 32'(rq[0].d));
         void'(rq.pop_front());
      end else begin
         chk("rd_valid_idle", 32'(rd_valid), 32'd0);
      end
      chk("disp_bank", 32'(disp_bank), 32'(m_bank));
      chk("swap_done", 32'(swap_done), 32'(m_swp));
      chk("swap_pending", 32'(swap_pending), 32'(m_pend || m_swp));
      if (erg) rq.push_back('{due: cyc_n + 1 + LAT, d: shadow[{m_bank, rd_addr}]});
      if (ewg) shadow[{!m_bank, wr_addr}] = wr_data;
      m_en = erg || ewg;
      m_we = ewg;
      if (erg) m_addr = {m_bank, rd_addr};
      if (ewg) begin
         m_addr = {!m_bank, wr_addr};
         m_wd   = wr_data;
      end
      if (wr_req && !ewg) m_wait = (m_wait < STARVE) ? m_wait + 1 : STARVE;
      else                m_wait = 0;
      rise = vblank && !m_vq;
      nsw  = m_pend && rise;
      if (nsw) begin
         m_bank = !m_bank;
         m_pend = 0;
      end else if (!m_pend && !m_swp && swap_req) begin
         m_pend = 1;
      end
      m_swp = nsw;
      m_vq  = vblank;
      g_rg  = erg;
      g_wg  = ewg;
      cyc_n++;
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      bit          rr;
      logic [8:0]  ra;
      bit          wr;
      logic [8:0]  wa;
      logic [3:0]  wd;
      bit          erg;
      bit          ewg;
      bit          ck;
      logic [9:0]  eaddr;
      bit          ewe;
   } vec_t;

   vec_t tbl [$];
   int   vcnt;

   initial begin
      total = 0;
      bad   = 0;
      cyc_n = 0;
      for (int i = 0; i < 1024; i++) begin
         ram[i]    = 4'((i * 7) ^ (i >> 3));
         shadow[i] = 4'((i * 7) ^ (i >> 3));
      end
      rst = 1; rd_req = 0; rd_addr = '0; wr_req = 0; wr_addr = '0;
      wr_data = '0; swap_req = 0; vblank = 1;
      model_reset();
      #12;
      chk("rst_mem_en", 32'(mem_en), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_rd_valid", 32'(rd_valid), 32'd0);
      chk("rst_disp_bank", 32'(disp_bank), 32'd0);
      chk("rst_swap_pending", 32'(swap_pending), 32'd0);
      @(posedge clk);
      #1;
      rst = 0;

      // Directed arbitration vectors
      for (int i = 0; i < 4; i++)
         tbl.push_back('{1, 9'(16 + i), 0, 9'h0, 4'h0, 1, 0, 1, 10'(16 + i), 0});
      tbl.push_back('{0, 9'h0, 0, 9'h0, 4'h0, 0, 0, 0, 10'h0, 0});
      for (int i = 0; i < 3; i++)
         tbl.push_back('{0, 9'h0, 1, 9'(32 + i), 4'(i + 1), 0, 1, 1, 10'(512 + 32 + i), 1});
      tbl.push_back('{0, 9'h0, 0, 9'h0, 4'h0, 0, 0, 0, 10'h0, 0});
      for (int i = 0; i < 8; i++)
         tbl.push_back('{1, 9'(48 + i), 1, 9'h1AB, 4'h5, 1, 0, 1, 10'(48 + i), 0});
      tbl.push_back('{1, 9'h038, 1, 9'h1AB, 4'h5, 0, 1, 1, 10'h3AB, 1});
      tbl.push_back('{1, 9'h038, 0, 9'h0, 4'h0, 1, 0, 1, 10'h038, 0});
      tbl.push_back('{1, 9'h040, 1, 9'h055, 4'h9, 1, 0, 1, 10'h040, 0});
      tbl.push_back('{0, 9'h0, 1, 9'h055, 4'h9, 0, 1, 1, 10'h255, 1});
      for (int i = 0; i < 3; i++)
         tbl.push_back('{0, 9'h0, 0, 9'h0, 4'h0, 0, 0, 0, 10'h0, 0});

      foreach (tbl[i]) begin
         rd_req  = tbl[i].rr;
         rd_addr = tbl[i].ra;
         wr_req  = tbl[i].wr;
         wr_addr = tbl[i].wa;
         wr_data = tbl[i].wd;
         cyc();
         chk("tbl_rd_gnt", 32'(s_rg), 32'(tbl[i].erg));
         chk("tbl_wr_gnt", 32'(s_wg), 32'(tbl[i].ewg));
         if (tbl[i].ck) begin
            chk("tbl_cmd_addr", 32'(mem_addr), 32'(tbl[i].eaddr));
            chk("tbl_cmd_we", 32'(mem_we), 32'(tbl[i].ewe));
         end
      end
      rd_req = 0;
      wr_req = 0;

      // Swap at vblank, second request while pending ignored
      vblank = 0;
      repeat (2) cyc();
      swap_req = 1;
      cyc();
      swap_req = 0;
      chk("sw_pend_set", 32'(swap_pending), 32'd1);
      repeat (5) cyc();
      swap_req = 1;
      cyc();
      swap_req = 0;
      repeat (13) cyc();
      chk("sw_bank_before", 32'(disp_bank), 32'd0);
      vblank = 1;
      cyc();
      chk("sw_bank_after", 32'(disp_bank), 32'd1);
      chk("sw_done_pulse", 32'(swap_done), 32'd1);
      cyc();
      chk("sw_done_clear", 32'(swap_done), 32'd0);
      chk("sw_pend_clear", 32'(swap_pending), 32'd0);
      wr_req = 1; wr_addr = 9'h077; wr_data = 4'hA;
      cyc();
      wr_req = 0;
      chk("sw_wr_bank0", 32'(mem_addr), 32'h077);
      vblank = 0;
      repeat (2) cyc();
      vblank = 1;
      repeat (2) cyc();
      chk("sw_no_double", 32'(disp_bank), 32'd1);

      // Request on the rising-edge cycle waits for the following edge
      vblank = 0;
      repeat (3) cyc();
      vblank = 1;
      swap_req = 1;
      cyc();
      swap_req = 0;
      repeat (3) cyc();
      vblank = 0;
      repeat (3) cyc();
      chk("edge_no_swap", 32'(disp_bank), 32'd1);
      chk("edge_pending", 32'(swap_pending), 32'd1);
      vblank = 1;
      cyc();
      chk("edge_swap_bank", 32'(disp_bank), 32'd0);
      chk("edge_swap_done", 32'(swap_done), 32'd1);
      cyc();

      // Random traffic against the model
      vcnt = 5;
      for (int n = 0; n < 3000; n++) begin
         if (!rd_req || g_rg) begin
            rd_req  = ($urandom_range(0, 9) < 8);
            rd_addr = 9'($urandom);
         end
         if (!wr_req || g_wg) begin
            wr_req  = ($urandom_range(0, 9) < 5);
            wr_addr = 9'($urandom);
            wr_data = 4'($urandom);
         end
         swap_req = ($urandom_range(0, 39) == 0);
         vcnt--;
         if (vcnt == 0) begin
            vblank = !vblank;
            vcnt   = $urandom_range(3, 30);
         end
         cyc();
      end
      swap_req = 0;
      wr_req   = 0;
      rd_req   = 0;
      cyc();

      // Reset with reads in flight
      rd_req = 1; rd_addr = 9'h100;
      cyc();
      rd_addr = 9'h101;
      cyc();
      rd_req = 0;
      rst = 1;
      #1;
      chk("rst2_mem_en", 32'(mem_en), 32'd0);
      chk("rst2_rd_valid", 32'(rd_valid), 32'd0);
      chk("rst2_disp_bank", 32'(disp_bank), 32'd0);
      chk("rst2_swap_pending", 32'(swap_pending), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 0;
      model_reset();
      repeat (6) cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout cyc=%0d", cyc_n);
      $fatal(1, "timeout");
   end

endmodule
